// File: rtl/io_pkg.sv
// Shared definitions for the MMIO switch / 7-segment controller: register map,
// CTRL field positions and the active-low segment glyphs (bit 0 = segment a).
package io_pkg;

  localparam logic [7:0] ADDR_SW     = 8'h00;
  localparam logic [7:0] ADDR_HEX    = 8'h04;
  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h0C;

  localparam int CTRL_BLANK_LSB     = 0;
  localparam int CTRL_BLINK_LSB     = 8;
  localparam int CTRL_IRQ_EN_BIT    = 16;
  localparam int STATUS_CHANGED_BIT = 0;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Glyphs 0..F, with lowercase b and d so they differ from 8 and 0.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One switch bit: 2-FF synchronizer followed by a stable-sample counter that
// only lets a level through after DEBOUNCE_CYCLES identical samples.
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic d_out,
  output logic changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    prev_d = sync_q;
    cnt_d  = cnt_q;
    if (sync_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    // The counter saturates, so a stable level keeps being re-accepted harmlessly.
    db_d = db_q;
    if (cnt_q == CNT_MAX) begin
      db_d = prev_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign d_out   = db_q;
  assign changed = (db_d != db_q);

endmodule

// File: rtl/io_mmio_ctrl.sv
// Memory-mapped controller for debounced switches and a blinking/blanking
// 7-segment display, with a level interrupt on switch changes.
module io_mmio_ctrl
  import io_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int SW_WIDTH        = 10,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_PERIOD    = 32
) (
  input  logic                    clock_50,
  input  logic                    reset,
  input  logic [7:0]              bus_addr,
  input  logic [31:0]             bus_wdata,
  input  logic                    bus_we,
  input  logic                    bus_re,
  output logic [31:0]             bus_rdata,
  output logic                    bus_rvalid,
  input  logic [SW_WIDTH-1:0]     sw_in,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    sw_irq
);

  // Bus handshake: no backpressure. bus_we/bus_re are single-cycle strobes
  // sampled on the rising edge; a read in cycle N yields bus_rvalid for
  // exactly cycle N+1 with bus_rdata, which then holds until the next read.

  localparam int BW = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_PERIOD - 1);

  logic [SW_WIDTH-1:0] sw_db, sw_chg;

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_db
    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clock_50),
      .reset   (reset),
      .d_in    (sw_in[i]),
      .d_out   (sw_db[i]),
      .changed (sw_chg[i])
    );
  end

  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   blink_q, blink_d;
  logic                    irq_en_q, irq_en_d;
  logic                    changed_q, changed_d;
  logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    phase_q, phase_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;

  logic hit_sw, hit_hex, hit_ctrl, hit_status;
  logic [31:0] ctrl_rd, rd_word;
  logic status_clr;

  assign hit_sw     = (bus_addr[7:2] == ADDR_SW[7:2]);
  assign hit_hex    = (bus_addr[7:2] == ADDR_HEX[7:2]);
  assign hit_ctrl   = (bus_addr[7:2] == ADDR_CTRL[7:2]);
  assign hit_status = (bus_addr[7:2] == ADDR_STATUS[7:2]);

  always_comb begin
    hex_d      = hex_q;
    blank_d    = blank_q;
    blink_d    = blink_q;
    irq_en_d   = irq_en_q;
    status_clr = bus_we && hit_status && bus_wdata[STATUS_CHANGED_BIT];
    if (bus_we && hit_hex) begin
      hex_d = bus_wdata[4*NUM_DIGITS-1:0];
    end
    if (bus_we && hit_ctrl) begin
      blank_d  = bus_wdata[CTRL_BLANK_LSB +: NUM_DIGITS];
      blink_d  = bus_wdata[CTRL_BLINK_LSB +: NUM_DIGITS];
      irq_en_d = bus_wdata[CTRL_IRQ_EN_BIT];
    end
    // A change event in the same cycle as a clear keeps the flag set.
    changed_d = (|sw_chg) | (changed_q & ~status_clr);
  end

  // Reads sample the registered state, so a same-cycle write is not yet visible.
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_BLANK_LSB +: NUM_DIGITS] = blank_q;
    ctrl_rd[CTRL_BLINK_LSB +: NUM_DIGITS] = blink_q;
    ctrl_rd[CTRL_IRQ_EN_BIT]              = irq_en_q;
    rd_word = '0;
    if (hit_sw) begin
      rd_word = 32'(sw_db);
    end else if (hit_hex) begin
      rd_word = 32'(hex_q);
    end else if (hit_ctrl) begin
      rd_word = ctrl_rd;
    end else if (hit_status) begin
      rd_word[STATUS_CHANGED_BIT] = changed_q;
    end
    rdata_d  = bus_re ? rd_word : rdata_q;
    rvalid_d = bus_re;
  end

  always_comb begin
    if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      phase_d     = phase_q;
    end
  end

  always_comb begin
    seg_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (blank_q[k]) begin
        seg_d[7*k +: 7] = SEG_BLANK;
      end else if (blink_q[k] && phase_q) begin
        seg_d[7*k +: 7] = SEG_BLANK;
      end else begin
        seg_d[7*k +: 7] = hex_glyph(hex_q[4*k +: 4]);
      end
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      hex_q       <= '0;
      blank_q     <= '0;
      blink_q     <= '0;
      irq_en_q    <= 1'b0;
      changed_q   <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      seg_q       <= {NUM_DIGITS{GLYPH_TABLE[0]}};
    end else begin
      hex_q       <= hex_d;
      blank_q     <= blank_d;
      blink_q     <= blink_d;
      irq_en_q    <= irq_en_d;
      changed_q   <= changed_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      seg_q       <= seg_d;
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign hex_out    = seg_q;
  assign sw_irq     = changed_q & irq_en_q;

  logic unused_ok;
  assign unused_ok = ^{bus_addr[1:0], bus_wdata};

endmodule
